// File: rtl/gmm_operand_fetch.sv
// Operand feeder for the GMM score stage. It walks every (component, dimension) pair,
// issues the matching reads and outputs aligned {feature, mean, prec} beats with tags.
module gmm_operand_fetch #(
   parameter int FEAT_DIM = 39,
   parameter int MAX_COMP = 128,
   parameter int RD_LAT   = 1,
   parameter int FA_W     = (FEAT_DIM > 1) ? $clog2(FEAT_DIM) : 1,
   parameter int PA_W     = (MAX_COMP * FEAT_DIM > 1) ? $clog2(MAX_COMP * FEAT_DIM) : 1,
   parameter int CW       = $clog2(MAX_COMP + 1)
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic            start,
   input  logic [CW-1:0]   num_comp,
   output logic            busy,
   output logic            done,
   output logic            feat_rd_en,
   output logic [FA_W-1:0] feat_addr,
   input  logic [31:0]     feat_rd_data,
   output logic            param_rd_en,
   output logic [PA_W-1:0] param_addr,
   input  logic [31:0]     mean_rd_data,
   input  logic [31:0]     prec_rd_data,
   output logic            data_valid,
   output logic [31:0]     feature,
   output logic [31:0]     mean,
   output logic [31:0]     prec,
   output logic            last_dim,
   output logic [CW-1:0]   comp_idx
);
   localparam int DW = $clog2(RD_LAT + 1);
   localparam logic [CW-1:0]   MAX_N    = CW'(MAX_COMP);
   localparam logic [FA_W-1:0] LAST_DIM = FA_W'(FEAT_DIM - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_n;
   logic [CW-1:0]   r_comp;
   logic [FA_W-1:0] r_dim;
   logic [PA_W-1:0] r_paddr;
   logic [DW-1:0]   r_drain;
   logic            r_rd_en;
   logic            r_busy;
   logic            r_done;

   logic            r_tv [RD_LAT];
   logic            r_tl [RD_LAT];
   logic [CW-1:0]   r_tc [RD_LAT];

   logic            r_dv;
   logic [31:0]     r_feature;
   logic [31:0]     r_mean;
   logic [31:0]     r_prec;
   logic            r_last;
   logic [CW-1:0]   r_comp_idx;

   logic [CW-1:0]   w_n_clamped;
   logic            w_dim_wrap;
   logic            w_last_issue;

   assign w_n_clamped  = (num_comp > MAX_N) ? MAX_N : num_comp;
   assign w_dim_wrap   = (r_dim == LAST_DIM);
   assign w_last_issue = w_dim_wrap && (r_comp == (r_n - CW'(1)));

   // param_addr is a running counter so comp*FEAT_DIM+dim needs no multiplier
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_comp  <= '0;
         r_dim   <= '0;
         r_paddr <= '0;
         r_drain <= '0;
         r_rd_en <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_n     <= w_n_clamped;
                  r_comp  <= '0;
                  r_dim   <= '0;
                  r_paddr <= '0;
                  if (w_n_clamped == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                     r_rd_en <= 1'b1;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_last_issue) begin
                  r_rd_en <= 1'b0;
                  r_drain <= DW'(RD_LAT);
                  r_state <= S_DRAIN;
               end else begin
                  r_paddr <= r_paddr + PA_W'(1);
                  if (w_dim_wrap) begin
                     r_dim  <= '0;
                     r_comp <= r_comp + CW'(1);
                  end else begin
                     r_dim <= r_dim + FA_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               // last beat sits in the output register when the count reaches zero
               if (r_drain == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_drain <= r_drain - DW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_tv[i] <= 1'b0;
            r_tl[i] <= 1'b0;
            r_tc[i] <= '0;
         end
      end else begin
         r_tv[0] <= r_rd_en;
         r_tl[0] <= w_dim_wrap;
         r_tc[0] <= r_comp;
         for (int i = 1; i < RD_LAT; i++) begin
            r_tv[i] <= r_tv[i-1];
            r_tl[i] <= r_tl[i-1];
            r_tc[i] <= r_tc[i-1];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_dv       <= 1'b0;
         r_feature  <= '0;
         r_mean     <= '0;
         r_prec     <= '0;
         r_last     <= 1'b0;
         r_comp_idx <= '0;
      end else begin
         r_dv <= r_tv[RD_LAT-1];
         if (r_tv[RD_LAT-1]) begin
            r_feature  <= feat_rd_data;
            r_mean     <= mean_rd_data;
            r_prec     <= prec_rd_data;
            r_last     <= r_tl[RD_LAT-1];
            r_comp_idx <= r_tc[RD_LAT-1];
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign feat_rd_en  = r_rd_en;
   assign param_rd_en = r_rd_en;
   assign feat_addr   = r_dim;
   assign param_addr  = r_paddr;
   assign data_valid  = r_dv;
   assign feature     = r_feature;
   assign mean        = r_mean;
   assign prec        = r_prec;
   assign last_dim    = r_last;
   assign comp_idx    = r_comp_idx;

endmodule

// File: tb/tb_gmm_operand_fetch.sv
// Directed bench for gmm_operand_fetch: two instances (RD_LAT 1 and 3) share the stimulus,
// each with an address-coded memory model and a per-beat monitor.
module tb_gmm_operand_fetch;
   localparam int FEAT_DIM = 39;
   localparam int MAX_COMP = 128;
   localparam int FA_W = 6;
   localparam int PA_W = 13;
   localparam int CW   = 8;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic          aresetn;
   logic          start;
   logic [CW-1:0] num_comp;
   logic          clr_stats;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   logic            busy [2];
   logic            done [2];
   logic            feat_rd_en [2];
   logic [FA_W-1:0] feat_addr [2];
   logic            param_rd_en [2];
   logic [PA_W-1:0] param_addr [2];
   logic            data_valid [2];
   logic [31:0]     feature [2];
   logic [31:0]     mean [2];
   logic [31:0]     prec [2];
   logic            last_dim [2];
   logic [CW-1:0]   comp_idx [2];

   int s_rd_cnt [2];
   int s_first_rd [2];
   int s_dv_cnt [2];
   int s_first_dv [2];
   int s_last_dv [2];
   int s_done_cnt [2];
   int s_done_cyc [2];
   int s_busy_cnt [2];
   logic s_busy_at_done [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int L = (gi == 0) ? 1 : 3;
      logic [31:0] w_feat, w_mean, w_prec;
      logic [31:0] p_f [L];
      logic [31:0] p_m [L];
      logic [31:0] p_p [L];

      gmm_operand_fetch #(
         .FEAT_DIM(FEAT_DIM), .MAX_COMP(MAX_COMP), .RD_LAT(L)
      ) u_dut (
         .aclk(aclk), .aresetn(aresetn), .start(start), .num_comp(num_comp),
         .busy(busy[gi]), .done(done[gi]),
         .feat_rd_en(feat_rd_en[gi]), .feat_addr(feat_addr[gi]), .feat_rd_data(w_feat),
         .param_rd_en(param_rd_en[gi]), .param_addr(param_addr[gi]),
         .mean_rd_data(w_mean), .prec_rd_data(w_prec),
         .data_valid(data_valid[gi]), .feature(feature[gi]), .mean(mean[gi]), .prec(prec[gi]),
         .last_dim(last_dim[gi]), .comp_idx(comp_idx[gi])
      );

      // memory model: address-coded words, junk when not enabled so misaligned captures show
      assign w_feat = p_f[L-1];
      assign w_mean = p_m[L-1];
      assign w_prec = p_p[L-1];
      always @(posedge aclk) begin
         p_f[0] <= feat_rd_en[gi]  ? (32'h1000 + 32'(feat_addr[gi]))  : 32'hDEAD_0001;
         p_m[0] <= param_rd_en[gi] ? (32'h2000 + 32'(param_addr[gi])) : 32'hDEAD_0002;
         p_p[0] <= param_rd_en[gi] ? (32'h3000 + 32'(param_addr[gi])) : 32'hDEAD_0003;
         for (int s = 1; s < L; s++) begin
            p_f[s] <= p_f[s-1];
            p_m[s] <= p_m[s-1];
            p_p[s] <= p_p[s-1];
         end
      end

      int rd_cnt = 0, first_rd = -1, dv_cnt = 0, first_dv = -1, last_dv = -1;
      int done_cnt = 0, done_cyc = -1, busy_cnt = 0;
      logic busy_at_done = 1'b0;

      always @(negedge aclk) begin
         if (clr_stats) begin
            rd_cnt <= 0; first_rd <= -1; dv_cnt <= 0; first_dv <= -1; last_dv <= -1;
            done_cnt <= 0; done_cyc <= -1; busy_cnt <= 0; busy_at_done <= 1'b0;
         end else begin
            if (feat_rd_en[gi]) begin
               if (rd_cnt == 0) first_rd <= cyc;
               rd_cnt <= rd_cnt + 1;
               check($sformatf("L%0d_param_rd_en", L), 64'(param_rd_en[gi]), 64'd1);
            end
            if (data_valid[gi]) begin
               if (dv_cnt == 0) first_dv <= cyc;
               last_dv <= cyc;
               dv_cnt  <= dv_cnt + 1;
               check($sformatf("L%0d_beat%0d_feature", L, dv_cnt), 64'(feature[gi]),
                     64'(32'h1000 + 32'(dv_cnt % FEAT_DIM)));
               check($sformatf("L%0d_beat%0d_mean", L, dv_cnt), 64'(mean[gi]),
                     64'(32'h2000 + 32'(dv_cnt)));
               check($sformatf("L%0d_beat%0d_prec", L, dv_cnt), 64'(prec[gi]),
                     64'(32'h3000 + 32'(dv_cnt)));
               check($sformatf("L%0d_beat%0d_last_dim", L, dv_cnt), 64'(last_dim[gi]),
                     64'((dv_cnt % FEAT_DIM) == FEAT_DIM - 1));
               check($sformatf("L%0d_beat%0d_comp_idx", L, dv_cnt), 64'(comp_idx[gi]),
                     64'(dv_cnt / FEAT_DIM));
            end
            if (done[gi]) begin
               done_cnt     <= done_cnt + 1;
               done_cyc     <= cyc;
               busy_at_done <= busy[gi];
            end
            if (busy[gi]) busy_cnt <= busy_cnt + 1;
         end
      end

      assign s_rd_cnt[gi]       = rd_cnt;
      assign s_first_rd[gi]     = first_rd;
      assign s_dv_cnt[gi]       = dv_cnt;
      assign s_first_dv[gi]     = first_dv;
      assign s_last_dv[gi]      = last_dv;
      assign s_done_cnt[gi]     = done_cnt;
      assign s_done_cyc[gi]     = done_cyc;
      assign s_busy_cnt[gi]     = busy_cnt;
      assign s_busy_at_done[gi] = busy_at_done;
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_stats();
      @(negedge aclk);
      #1 clr_stats = 1'b1;
      @(negedge aclk);
      #1 clr_stats = 1'b0;
   endtask

   // pulses start for one edge; returns the cycle number of the first RUN cycle
   task automatic pulse_start(input int n, output int sc);
      tick();
      num_comp = CW'(n);
      start    = 1'b1;
      tick();
      start = 1'b0;
      sc    = cyc;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while ((s_done_cnt[0] == 0 || s_done_cnt[1] == 0) && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_timeout"}, 64'(k >= budget), 64'd0);
      repeat (8) tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_i%0d_busy", tag, i), 64'(busy[i]), 64'd0);
         check($sformatf("%s_i%0d_done", tag, i), 64'(done[i]), 64'd0);
         check($sformatf("%s_i%0d_rd_en", tag, i), 64'({feat_rd_en[i], param_rd_en[i]}), 64'd0);
         check($sformatf("%s_i%0d_addr", tag, i), 64'({feat_addr[i], param_addr[i]}), 64'd0);
         check($sformatf("%s_i%0d_dv", tag, i), 64'({data_valid[i], last_dim[i]}), 64'd0);
         check($sformatf("%s_i%0d_data", tag, i), 64'(feature[i] | mean[i] | prec[i]), 64'd0);
         check($sformatf("%s_i%0d_comp_idx", tag, i), 64'(comp_idx[i]), 64'd0);
      end
   endtask

   task automatic run_check(input string tag, input int n, input int sc);
      for (int i = 0; i < 2; i++) begin
         int lat   = (i == 0) ? 1 : 3;
         int beats = n * FEAT_DIM;
         check($sformatf("%s_i%0d_done_cnt", tag, i), 64'(s_done_cnt[i]), 64'd1);
         check($sformatf("%s_i%0d_busy_at_done", tag, i), 64'(s_busy_at_done[i]), 64'd0);
         if (n == 0) begin
            check($sformatf("%s_i%0d_rd_cnt", tag, i), 64'(s_rd_cnt[i]), 64'd0);
            check($sformatf("%s_i%0d_dv_cnt", tag, i), 64'(s_dv_cnt[i]), 64'd0);
            check($sformatf("%s_i%0d_busy_cnt", tag, i), 64'(s_busy_cnt[i]), 64'd0);
            check($sformatf("%s_i%0d_done_cyc", tag, i), 64'(s_done_cyc[i]), 64'(sc));
         end else begin
            check($sformatf("%s_i%0d_rd_cnt", tag, i), 64'(s_rd_cnt[i]), 64'(beats));
            check($sformatf("%s_i%0d_first_rd", tag, i), 64'(s_first_rd[i]), 64'(sc));
            check($sformatf("%s_i%0d_dv_cnt", tag, i), 64'(s_dv_cnt[i]), 64'(beats));
            check($sformatf("%s_i%0d_first_dv", tag, i), 64'(s_first_dv[i]), 64'(sc + lat + 1));
            check($sformatf("%s_i%0d_last_dv", tag, i), 64'(s_last_dv[i]), 64'(sc + lat + beats));
            check($sformatf("%s_i%0d_done_cyc", tag, i), 64'(s_done_cyc[i]),
                  64'(sc + lat + beats + 1));
            check($sformatf("%s_i%0d_busy_cnt", tag, i), 64'(s_busy_cnt[i]), 64'(beats + lat + 1));
            check($sformatf("%s_i%0d_param_addr", tag, i), 64'(param_addr[i]), 64'(beats - 1));
            check($sformatf("%s_i%0d_comp_idx", tag, i), 64'(comp_idx[i]), 64'(n - 1));
         end
      end
   endtask

   initial begin
      int sc;
      int k;
      aresetn   = 1'b0;
      start     = 1'b0;
      num_comp  = '0;
      clr_stats = 1'b1;
      repeat (3) tick();
      check_outputs_zero("reset");
      aresetn = 1'b1;
      tick();
      clear_stats();

      // two components, contiguous 78 beats
      pulse_start(2, sc);
      wait_done("n2", 300);
      run_check("n2", 2, sc);
      $display("[TB] run num_comp=2 finished at cycle %0d", cyc);

      // zero components: only a done pulse
      clear_stats();
      pulse_start(0, sc);
      wait_done("n0", 50);
      run_check("n0", 0, sc);
      $display("[TB] run num_comp=0 finished at cycle %0d", cyc);

      // start re-pulsed mid-run is ignored
      clear_stats();
      pulse_start(1, sc);
      k = 0;
      while (s_dv_cnt[0] < 20 && k < 200) begin tick(); k++; end
      check("repulse_wait_timeout", 64'(k >= 200), 64'd0);
      num_comp = CW'(5);
      start    = 1'b1;
      tick();
      start = 1'b0;
      wait_done("repulse", 300);
      run_check("repulse", 1, sc);
      $display("[TB] run num_comp=1 with start re-pulse finished at cycle %0d", cyc);

      // asynchronous reset mid-run, then a clean run
      clear_stats();
      pulse_start(3, sc);
      k = 0;
      while (s_rd_cnt[0] < 50 && k < 300) begin tick(); k++; end
      check("abort_wait_timeout", 64'(k >= 300), 64'd0);
      @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      check_outputs_zero("abort");
      repeat (2) tick();
      aresetn = 1'b1;
      clear_stats();
      repeat (8) tick();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("post_abort_i%0d_dv", i), 64'(s_dv_cnt[i]), 64'd0);
         check($sformatf("post_abort_i%0d_rd", i), 64'(s_rd_cnt[i]), 64'd0);
         check($sformatf("post_abort_i%0d_done", i), 64'(s_done_cnt[i]), 64'd0);
      end
      pulse_start(1, sc);
      wait_done("after_abort", 300);
      run_check("after_abort", 1, sc);
      $display("[TB] run num_comp=1 after reset abort finished at cycle %0d", cyc);

      // component count above MAX_COMP is clamped
      clear_stats();
      pulse_start(200, sc);
      wait_done("clamp", 6000);
      run_check("clamp", MAX_COMP, sc);
      $display("[TB] run num_comp=200 (clamped) finished at cycle %0d", cyc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gmm_operand_fetch.md
Name: gmm_operand_fetch

Overview:
- Upstream feeder for the per-dimension GMM score stage, which computes (feature-mean)^2*prec.
- Walks every (component, dimension) pair of a Gaussian mixture.
- Issues synchronous reads to the feature memory and the mean/precision memories.
- Presents aligned {feature, mean, prec} words with a data_valid strobe, one dimension per cycle, plus tags for the downstream accumulator.
- The score stage has no input back-pressure, so this block never stalls once running.

Parameters:
FEAT_DIM, 39, dimensions per feature vector (>=1)
MAX_COMP, 128, maximum Gaussian components per run (>=1)
RD_LAT, 1, read latency of the external memories in cycles, from rd_en to valid rd_data (>=1)
FA_W, $clog2(FEAT_DIM), width of feat_addr (min 1)
PA_W, $clog2(MAX_COMP*FEAT_DIM), width of param_addr
CW, $clog2(MAX_COMP+1), width of num_comp and comp_idx

Ports:
aclk  in  1  clock, all logic rising-edge
aresetn  in  1  asynchronous active-low reset
start  in  1  run request; sampled only in IDLE
num_comp  in  CW  components this run; latched on accepted start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
feat_rd_en  out  1  feature memory read enable
feat_addr  out  FA_W  feature memory address = dimension index
feat_rd_data  in  32  feature word, valid RD_LAT cycles after feat_rd_en
param_rd_en  out  1  mean/prec memory read enable (shared address)
param_addr  out  PA_W  = comp*FEAT_DIM + dim
mean_rd_data  in  32  mean word, same timing as feat_rd_data
prec_rd_data  in  32  precision word, same timing as feat_rd_data
data_valid  out  1  output beat valid
feature  out  32  registered feature word
mean  out  32  registered mean word
prec  out  32  registered precision word
last_dim  out  1  high on the beat with dim = FEAT_DIM-1
comp_idx  out  CW  component index of the current beat

Behaviour:
- Reset (async assert, sync release): state IDLE, counters 0. busy, done, rd_ens, data_valid, last_dim = 0. Addresses, data outputs and comp_idx = 0. All in-flight pipeline valid bits are cleared, so in-flight reads are discarded.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 latches n = min(num_comp, MAX_COMP) and clears the counters.
  - If n=0: go to IDLE, no reads issued, done=1 on the next cycle, busy stays 0.
  - Otherwise go to RUN.
- RUN:
  - feat_rd_en = param_rd_en = 1 every cycle.
  - The first RUN cycle is the cycle after the start edge.
  - dim increments by 1 per cycle; at FEAT_DIM-1 it wraps to 0 and comp increments.
  - param_addr is a running counter: +1 per cycle, reset to 0 only at start. No multiplier.
  - feat_addr = dim.
  - After the issue with comp=n-1 and dim=FEAT_DIM-1, go to DRAIN.
- DRAIN:
  - rd_ens = 0.
  - Hold for RD_LAT+1 cycles, until the last beat has left the output register.
  - Then go to IDLE; done=1 in the following cycle.
  - busy is high through RUN and DRAIN, low in the cycle done is high.
- Datapath:
  - The tags {valid, last_dim, comp} travel through an RD_LAT-deep shift register alongside the read.
  - At tap RD_LAT, the rd_data words and the tags are captured into the output registers.
  - data_valid is therefore high exactly RD_LAT+1 cycles after the matching rd_en.
  - Output beats are contiguous: n*FEAT_DIM consecutive data_valid cycles.
  - When data_valid=0, feature/mean/prec/last_dim/comp_idx hold their last values.
- start while busy: ignored, with no effect on counters or n.
- start asserted in the same cycle as done: accepted (state is IDLE).
- num_comp > MAX_COMP: clamped to MAX_COMP.
- Changes to num_comp after acceptance: no effect.
- Reset mid-run: immediate abort per the reset values above; no done pulse.

Test Plan:
- Defaults, num_comp=2, memories return addr-coded data (feat=0x1000+addr, mean=0x2000+addr, prec=0x3000+addr) -> rd_en high 78 cycles starting 1 cycle after start. data_valid high for 78 contiguous cycles, starting RD_LAT+1=2 cycles after the first rd_en. Beat k has mean=0x2000+k and feature=0x1000+(k mod 39). last_dim on beats 38 and 77. comp_idx 0 then 1. done 1 cycle after the last beat.
- num_comp=0 -> no rd_en, no data_valid, busy stays 0, done pulses exactly 1 cycle after start.
- start re-pulsed at beat 20 of a num_comp=1 run -> exactly 39 beats, param_addr ends at 38, a single done.
- aresetn dropped at issue cycle 50 of a num_comp=3 run -> all outputs 0 asynchronously. After release, no stale data_valid. A new start with num_comp=1 yields 39 clean beats.
- RD_LAT=3, num_comp=1 -> data_valid first high 4 cycles after the first rd_en. Values stay aligned, with no skew between feature/mean/prec.
- num_comp=200, MAX_COMP=128 -> 128*39=4992 beats, final comp_idx=127, final param_addr=4991.
